// File: rtl/conv_pkg.sv
// -----------------------------------------------------------------------------
// conv_pkg
// Shared widths, types and RGB565 helpers for the 3x3 convolution block
// (convolution_3x3 and its per-channel MAC, conv_channel_mac).
// No ports; imported with `import conv_pkg::*;`.
// -----------------------------------------------------------------------------
package conv_pkg;

    localparam int R_W     = 5;
    localparam int G_W     = 6;
    localparam int B_W     = 5;
    localparam int COEFF_W = 8;
    localparam int PROD_W  = 15;
    localparam int ACC_W   = 20;
    localparam int SHIFT_W = 4;
    localparam int NTAPS   = 9;

    typedef logic signed [COEFF_W-1:0] coeff_t;
    typedef logic signed [PROD_W-1:0]  prod_t;
    typedef logic signed [ACC_W-1:0]   acc_t;

    function automatic logic [R_W-1:0] rgb_r(input logic [15:0] px);
        return px[15:11];
    endfunction

    function automatic logic [G_W-1:0] rgb_g(input logic [15:0] px);
        return px[10:5];
    endfunction

    function automatic logic [B_W-1:0] rgb_b(input logic [15:0] px);
        return px[4:0];
    endfunction

    function automatic logic [15:0] rgb_pack(input logic [R_W-1:0] r,
                                             input logic [G_W-1:0] g,
                                             input logic [B_W-1:0] b);
        return {r, g, b};
    endfunction

endpackage

// File: rtl/conv_channel_mac.sv
// -----------------------------------------------------------------------------
// conv_channel_mac
// One colour channel of the 3x3 convolution: nine multiplies, an adder tree,
// an arithmetic right shift and a clamp to the channel range. Covers pipeline
// stages S2..S4; the result register is the S4 output.
//
// Optional build macro: CONV_ABS_EN -- when defined, the shifted sum is
// replaced by its absolute value before clamping (edge-detect kernels);
// otherwise negative sums clamp to 0. Latency is the same either way.
//
// Ports:
//   clk_in    system clock
//   rst_in    synchronous active-high reset (clears the result register only)
//   pix_in    nine unsigned channel samples, index = row*3+col
//   coeff_in  nine signed 8-bit coefficients, same indexing
//   shift_in  right-shift amount, captured alongside the products
//   en_s4_in  result register update enable (valid of the sample in S3)
//   chan_out  clamped channel result, held while en_s4_in is low
// -----------------------------------------------------------------------------
module conv_channel_mac
    import conv_pkg::*;
#(
    parameter int CH_W = 5
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic [NTAPS-1:0][CH_W-1:0]    pix_in,
    input  logic [NTAPS-1:0][COEFF_W-1:0] coeff_in,
    input  logic [SHIFT_W-1:0]            shift_in,
    input  logic                          en_s4_in,
    output logic [CH_W-1:0]               chan_out
);

    localparam acc_t CH_MAX = acc_t'((1 << CH_W) - 1);

    prod_t              prod_p2_d [NTAPS];
    prod_t              prod_p2_q [NTAPS];
    logic [SHIFT_W-1:0] shift_p2_d, shift_p2_q;
    acc_t               acc_p3_d, acc_p3_q;
    logic [SHIFT_W-1:0] shift_p3_d, shift_p3_q;
    logic [CH_W-1:0]    chan_p4_d, chan_p4_q;

    function automatic acc_t shift_sum(input acc_t v, input logic [SHIFT_W-1:0] s);
        return v >>> s;
    endfunction

    function automatic logic [CH_W-1:0] sat_chan(input acc_t v);
        acc_t m;
`ifdef CONV_ABS_EN
        m = (v < 0) ? -v : v;
`else
        m = v;
`endif
        if (m < 0)
            return '0;
        else if (m > CH_MAX)
            return CH_MAX[CH_W-1:0];
        else
            return m[CH_W-1:0];
    endfunction

    always_comb begin
        // S2: products; the shift is carried with them so a coefficient load
        // switches coefficients and shift on the same pixel.
        for (int i = 0; i < NTAPS; i++) begin
            prod_p2_d[i] = prod_t'($signed({1'b0, pix_in[i]})) * prod_t'(coeff_t'(coeff_in[i]));
        end
        shift_p2_d = shift_in;

        // S3: accumulate; 9 * |8064| fits easily in 20 bits.
        acc_p3_d = '0;
        for (int i = 0; i < NTAPS; i++) begin
            acc_p3_d = acc_p3_d + acc_t'(prod_p2_q[i]);
        end
        shift_p3_d = shift_p2_q;

        // S4: shift and clamp, held when no valid sample is present.
        chan_p4_d = chan_p4_q;
        if (en_s4_in)
            chan_p4_d = sat_chan(shift_sum(acc_p3_q, shift_p3_q));
    end

    always_ff @(posedge clk_in) begin
        prod_p2_q  <= prod_p2_d;
        shift_p2_q <= shift_p2_d;
        acc_p3_q   <= acc_p3_d;
        shift_p3_q <= shift_p3_d;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in)
            chan_p4_q <= '0;
        else
            chan_p4_q <= chan_p4_d;
    end

    assign chan_out = chan_p4_q;

endmodule

// File: rtl/convolution_3x3.sv
// -----------------------------------------------------------------------------
// convolution_3x3
// Takes one 3-row RGB565 column per valid cycle from the line buffer, builds a
// sliding 3x3 window, applies a runtime-loadable signed kernel to each colour
// channel, shifts/clamps and emits one RGB565 pixel with hcount/vcount
// realigned to the window centre. Latency is 4 cycles, one pixel per cycle.
//
// Optional build macro: CONV_ABS_EN (see conv_channel_mac) -- absolute value
// of the shifted sum instead of clamping negatives to 0.
//
// Ports:
//   clk_in, rst_in   clock, synchronous active-high reset
//   data_in          RGB565 column, [0]=top row, [2]=bottom row
//   data_valid_in    column valid
//   hcount_in        column index of data_in
//   vcount_in        line index of the centre row
//   coeff_in         signed kernel, index = row*3+col, col 0 = leftmost
//   shift_in         right-shift amount 0..15
//   coeff_load_in    latch coeff_in/shift_in at this edge
//   line_out         filtered RGB565 pixel (held between valid outputs)
//   hcount_out       centre column of the emitted pixel
//   vcount_out       line index of the emitted pixel
//   data_valid_out   output valid
// -----------------------------------------------------------------------------
module convolution_3x3
    import conv_pkg::*;
#(
    parameter int HRES = 1280,
    parameter int VRES = 720,
    parameter int K    = 3
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic [K-1:0][15:0]   data_in,
    input  logic                 data_valid_in,
    input  logic [10:0]          hcount_in,
    input  logic [9:0]           vcount_in,
    input  logic [K*K-1:0][7:0]  coeff_in,
    input  logic [3:0]           shift_in,
    input  logic                 coeff_load_in,
    output logic [15:0]          line_out,
    output logic [10:0]          hcount_out,
    output logic [9:0]           vcount_out,
    output logic                 data_valid_out
);

    localparam int CW = K * K * 8;
    // Identity kernel: centre tap = 1, all others 0.
    localparam logic [K*K-1:0][7:0] COEFF_ID = CW'(1) << (8 * (K * K / 2));

    // Window indexed [col][row]; col 0 is the oldest (leftmost) column.
    logic [K-1:0][K-1:0][15:0] win_d, win_q;
    logic [K*K-1:0][7:0]       coeff_d, coeff_q;
    logic [3:0]                shift_d, shift_q;

    logic        vld_p1_d, vld_p1_q;
    logic        vld_p2_d, vld_p2_q;
    logic        vld_p3_d, vld_p3_q;
    logic        vld_p4_d, vld_p4_q;
    logic [10:0] hcnt_p1_d, hcnt_p1_q, hcnt_p2_q, hcnt_p3_q;
    logic [9:0]  vcnt_p1_d, vcnt_p1_q, vcnt_p2_q, vcnt_p3_q;
    logic [10:0] hcount_out_d, hcount_out_q;
    logic [9:0]  vcount_out_d, vcount_out_q;

    logic [NTAPS-1:0][R_W-1:0] r_pix;
    logic [NTAPS-1:0][G_W-1:0] g_pix;
    logic [NTAPS-1:0][B_W-1:0] b_pix;
    logic [R_W-1:0]            r_ch;
    logic [G_W-1:0]            g_ch;
    logic [B_W-1:0]            b_ch;

    always_comb begin
        // S1: window shift with zero padding at the left edge of each line.
        win_d = win_q;
        if (data_valid_in) begin
            if (hcount_in == '0) begin
                win_d[0] = '0;
                win_d[1] = '0;
            end else begin
                win_d[0] = win_q[1];
                win_d[1] = win_q[2];
            end
            win_d[2] = data_in;
        end

        coeff_d = coeff_q;
        shift_d = shift_q;
        if (coeff_load_in) begin
            coeff_d = coeff_in;
            shift_d = shift_in;
        end

        // Column 0 only primes the window; the centre lags the input by one.
        vld_p1_d  = data_valid_in && (hcount_in != '0) &&
                    (hcount_in < 11'(HRES)) && (vcount_in < 10'(VRES));
        hcnt_p1_d = hcount_in - 11'd1;
        vcnt_p1_d = vcount_in;

        vld_p2_d = vld_p1_q;
        vld_p3_d = vld_p2_q;
        vld_p4_d = vld_p3_q;

        hcount_out_d = hcount_out_q;
        vcount_out_d = vcount_out_q;
        if (vld_p3_q) begin
            hcount_out_d = hcnt_p3_q;
            vcount_out_d = vcnt_p3_q;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            win_q        <= '0;
            coeff_q      <= COEFF_ID;
            shift_q      <= '0;
            vld_p1_q     <= 1'b0;
            vld_p2_q     <= 1'b0;
            vld_p3_q     <= 1'b0;
            vld_p4_q     <= 1'b0;
            hcount_out_q <= '0;
            vcount_out_q <= '0;
        end else begin
            win_q        <= win_d;
            coeff_q      <= coeff_d;
            shift_q      <= shift_d;
            vld_p1_q     <= vld_p1_d;
            vld_p2_q     <= vld_p2_d;
            vld_p3_q     <= vld_p3_d;
            vld_p4_q     <= vld_p4_d;
            hcount_out_q <= hcount_out_d;
            vcount_out_q <= vcount_out_d;
        end
    end

    // S1 -> S3 position tags ride alongside the channel data.
    always_ff @(posedge clk_in) begin
        hcnt_p1_q <= hcnt_p1_d;
        vcnt_p1_q <= vcnt_p1_d;
        hcnt_p2_q <= hcnt_p1_q;
        vcnt_p2_q <= vcnt_p1_q;
        hcnt_p3_q <= hcnt_p2_q;
        vcnt_p3_q <= vcnt_p2_q;
    end

    // S1 -> S2: split the window into per-channel taps, index = row*K+col.
    always_comb begin
        r_pix = '0;
        g_pix = '0;
        b_pix = '0;
        for (int row = 0; row < K; row++) begin
            for (int col = 0; col < K; col++) begin
                r_pix[row*K+col] = rgb_r(win_q[col][row]);
                g_pix[row*K+col] = rgb_g(win_q[col][row]);
                b_pix[row*K+col] = rgb_b(win_q[col][row]);
            end
        end
    end

    conv_channel_mac #(.CH_W(R_W)) u_mac_r (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .pix_in   (r_pix),
        .coeff_in (coeff_q),
        .shift_in (shift_q),
        .en_s4_in (vld_p3_q),
        .chan_out (r_ch)
    );

    conv_channel_mac #(.CH_W(G_W)) u_mac_g (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .pix_in   (g_pix),
        .coeff_in (coeff_q),
        .shift_in (shift_q),
        .en_s4_in (vld_p3_q),
        .chan_out (g_ch)
    );

    conv_channel_mac #(.CH_W(B_W)) u_mac_b (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .pix_in   (b_pix),
        .coeff_in (coeff_q),
        .shift_in (shift_q),
        .en_s4_in (vld_p3_q),
        .chan_out (b_ch)
    );

    assign line_out       = rgb_pack(r_ch, g_ch, b_ch);
    assign hcount_out     = hcount_out_q;
    assign vcount_out     = vcount_out_q;
    assign data_valid_out = vld_p4_q;

endmodule

// File: tb/tb_convolution_3x3.sv
module tb_convolution_3x3;

    logic             clk_in = 1'b0;
    logic             rst_in = 1'b1;
    logic [2:0][15:0] data_in = '0;
    logic             data_valid_in = 1'b0;
    logic [10:0]      hcount_in = '0;
    logic [9:0]       vcount_in = '0;
    logic [8:0][7:0]  coeff_in = '0;
    logic [3:0]       shift_in = '0;
    logic             coeff_load_in = 1'b0;
    logic [15:0]      line_out;
    logic [10:0]      hcount_out;
    logic [9:0]       vcount_out;
    logic             data_valid_out;

    int errors = 0;
    int checks = 0;

    // Expected-output delay line: entry pushed with an input appears 4 edges later.
    logic        dl_v  [4];
    logic [15:0] dl_px [4];
    logic [10:0] dl_h  [4];
    logic [9:0]  dl_vc [4];
    logic [15:0] last_px;
    logic [10:0] last_h;
    logic [9:0]  last_vc;

    logic [15:0] tv [10] = '{16'hA001, 16'hA002, 16'hA003, 16'hA004, 16'hA005,
                             16'hA006, 16'hA007, 16'hA008, 16'hA009, 16'hA00A};
    logic [15:0] mv [10] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555,
                             16'h6666, 16'h7777, 16'h8888, 16'h9999, 16'hABCD};

    convolution_3x3 #(.HRES(16), .VRES(720), .K(3)) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .data_in        (data_in),
        .data_valid_in  (data_valid_in),
        .hcount_in      (hcount_in),
        .vcount_in      (vcount_in),
        .coeff_in       (coeff_in),
        .shift_in       (shift_in),
        .coeff_load_in  (coeff_load_in),
        .line_out       (line_out),
        .hcount_out     (hcount_out),
        .vcount_out     (vcount_out),
        .data_valid_out (data_valid_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_dl();
        for (int i = 0; i < 4; i++) begin
            dl_v[i] = 1'b0; dl_px[i] = '0; dl_h[i] = '0; dl_vc[i] = '0;
        end
        last_px = '0; last_h = '0; last_vc = '0;
    endtask

    task automatic check_out();
        if (dl_v[3]) begin
            last_px = dl_px[3];
            last_h  = dl_h[3];
            last_vc = dl_vc[3];
        end
        chk("valid", 16'(data_valid_out), 16'(dl_v[3]));
        chk("line", line_out, last_px);
        chk("hcount", 16'(hcount_out), 16'(last_h));
        chk("vcount", 16'(vcount_out), 16'(last_vc));
    endtask

    // One clock: drive a column (or idle), push its expected result, check outputs.
    task automatic step(input logic [15:0] t, input logic [15:0] m, input logic [15:0] b,
                        input logic v, input int h, input int vc, input logic ld,
                        input logic ev, input logic [15:0] ep);
        data_in[0] = t; data_in[1] = m; data_in[2] = b;
        data_valid_in = v; hcount_in = 11'(h); vcount_in = 10'(vc); coeff_load_in = ld;
        @(posedge clk_in); #1;
        data_valid_in = 1'b0; coeff_load_in = 1'b0;
        for (int i = 3; i > 0; i--) begin
            dl_v[i] = dl_v[i-1]; dl_px[i] = dl_px[i-1]; dl_h[i] = dl_h[i-1]; dl_vc[i] = dl_vc[i-1];
        end
        dl_v[0] = ev; dl_px[0] = ep; dl_h[0] = 11'(h - 1); dl_vc[0] = 10'(vc);
        check_out();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step('0, '0, '0, 1'b0, 0, 0, 1'b0, 1'b0, '0);
    endtask

    task automatic do_reset();
        rst_in = 1'b1;
        @(posedge clk_in); #1;
        rst_in = 1'b0; data_valid_in = 1'b0;
        clear_dl();
        chk("rst_valid", 16'(data_valid_out), 16'h0);
        chk("rst_line", line_out, 16'h0);
        chk("rst_hcount", 16'(hcount_out), 16'h0);
        chk("rst_vcount", 16'(vcount_out), 16'h0);
    endtask

    initial begin
        clear_dl();
        do_reset();

        // Identity kernel from reset, uniform 0x1234 over a full 16-pixel line.
        for (int h = 0; h < 16; h++)
            step(16'h1234, 16'h1234, 16'h1234, 1'b1, h, 5, 1'b0, h >= 1, 16'h1234);
        idle(4);

        // Box blur, shift 3, white field: left edge sees a zero column.
        coeff_in = {9{8'h01}}; shift_in = 4'd3;
        idle(1);
        step('0, '0, '0, 1'b0, 0, 0, 1'b1, 1'b0, '0);
        for (int h = 0; h < 6; h++)
            step(16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b1, h, 6, 1'b0, h >= 1,
                 (h == 1) ? 16'hBDF7 : 16'hFFFF);
        idle(4);

        // Laplacian: uniform field then a single bright centre pixel (R=10).
        coeff_in = {9{8'hFF}}; coeff_in[4] = 8'h08; shift_in = 4'd0;
        step('0, '0, '0, 1'b0, 0, 0, 1'b1, 1'b0, '0);
        for (int h = 0; h < 5; h++)
            step(16'h8410, 16'h8410, 16'h8410, 1'b1, h, 7, 1'b0, h >= 1,
                 (h == 1) ? 16'hFFFF : 16'h0000);
        step('0, '0,      '0, 1'b1, 0, 8, 1'b0, 1'b0, '0);
        step('0, '0,      '0, 1'b1, 1, 8, 1'b0, 1'b1, 16'h0000);
`ifdef CONV_ABS_EN
        step('0, 16'h5000, '0, 1'b1, 2, 8, 1'b0, 1'b1, 16'h5000);
        step('0, '0,      '0, 1'b1, 3, 8, 1'b0, 1'b1, 16'hF800);
        step('0, '0,      '0, 1'b1, 4, 8, 1'b0, 1'b1, 16'h5000);
`else
        step('0, 16'h5000, '0, 1'b1, 2, 8, 1'b0, 1'b1, 16'h0000);
        step('0, '0,      '0, 1'b1, 3, 8, 1'b0, 1'b1, 16'hF800);
        step('0, '0,      '0, 1'b1, 4, 8, 1'b0, 1'b1, 16'h0000);
`endif
        step('0, '0,      '0, 1'b1, 5, 8, 1'b0, 1'b1, 16'h0000);
        idle(4);

        // Top-left tap kernel with a gap after every valid column.
        coeff_in = '0; coeff_in[0] = 8'h01; shift_in = 4'd0;
        step('0, '0, '0, 1'b0, 0, 0, 1'b1, 1'b0, '0);
        for (int h = 0; h < 6; h++) begin
            step(tv[h], mv[h], 16'h0000, 1'b1, h, 9, 1'b0, h >= 1,
                 (h >= 2) ? tv[h-2] : 16'h0000);
            idle(1);
        end
        idle(4);

        // Reset restores identity; mid-line load switches at the next pixel.
        do_reset();
        step(tv[0], mv[0], '0, 1'b1, 0, 10, 1'b0, 1'b0, '0);
        step(tv[1], mv[1], '0, 1'b1, 1, 10, 1'b0, 1'b1, mv[0]);
        step(tv[2], mv[2], '0, 1'b1, 2, 10, 1'b0, 1'b1, mv[1]);
        coeff_in = '0; coeff_in[0] = 8'h01; shift_in = 4'd0;
        for (int h = 3; h < 9; h++)
            step(tv[h], mv[h], '0, 1'b1, h, 10, (h == 3), 1'b1, tv[h-2]);
        // Reset while a valid column is presented and three outputs are in flight.
        data_in[1] = mv[9]; data_valid_in = 1'b1; hcount_in = 11'd9; vcount_in = 10'd10;
        do_reset();
        idle(1);
        for (int h = 0; h < 5; h++)
            step(tv[h], mv[h], '0, 1'b1, h, 11, 1'b0, h >= 1, (h >= 1) ? mv[h-1] : 16'h0000);
        idle(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
